adc_spi_resp: RTL

ADC_SPI_RESP -- requirements
Module: adc_spi_resp

---
 rtl/adc_spi_resp.sv | 112 +++++++++++
 1 files changed

// File: rtl/adc_spi_resp.sv
// rtl/adc_spi_resp.sv - SPI mode-3 slave returning a 12-bit ADC sample per frame
// and latching the channel to be returned in the following frame.
module adc_spi_resp #(
  parameter logic [2:0] INIT_CH = 3'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic [2:0]  ch_sel,
  input  logic [11:0] ch_data,
  output logic        xfer_done,
  output logic        frame_err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_nx;
  logic [15:0] tx_shift, tx_nx;
  logic [13:0] rx_shift, rx_nx;
  logic [4:0]  bit_cnt, cnt_nx;
  logic [2:0]  ch_nx;
  logic        done_nx, err_nx;

  logic ss_s1, ss_s2, ss_d;
  logic sclk_s1, sclk_s2, sclk_d;
  logic mosi_s1, mosi_s2;
  logic [1:0] warm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {ss_s1, ss_s2, ss_d}       <= 3'b111;
      {sclk_s1, sclk_s2, sclk_d} <= 3'b111;
      {mosi_s1, mosi_s2}         <= 2'b00;
      warm_cnt                   <= 2'd0;
    end else begin
      {ss_s1, ss_s2, ss_d}       <= {SS_n, ss_s1, ss_s2};
      {sclk_s1, sclk_s2, sclk_d} <= {SCLK, sclk_s1, sclk_s2};
      {mosi_s1, mosi_s2}         <= {MOSI, mosi_s1};
      if (warm_cnt != 2'd3) warm_cnt <= warm_cnt + 2'd1;
    end
  end

  // The synchronizers reset high, so an SS_n held low through reset would look
  // like a fall; only trust the fall once every stage holds a real sample.
  logic ss_fall, ss_rise, sclk_fall, sclk_rise;
  assign ss_fall   = (warm_cnt == 2'd3) & ss_d & ~ss_s2;
  assign ss_rise   = ~ss_d & ss_s2;
  assign sclk_fall = sclk_d & ~sclk_s2;
  assign sclk_rise = ~sclk_d & sclk_s2;

  always_comb begin
    state_nx = state;
    tx_nx    = tx_shift;
    rx_nx    = rx_shift;
    cnt_nx   = bit_cnt;
    ch_nx    = ch_sel;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nx = SHIFT;
          tx_nx    = {4'b0000, ch_data};
          cnt_nx   = 5'd0;
        end
      end
      SHIFT: begin
        if (bit_cnt == 5'd16) ch_nx = rx_shift[13:11];
        if (ss_rise) begin
          state_nx = IDLE;
          done_nx  = (bit_cnt == 5'd16);
          err_nx   = (bit_cnt != 5'd0) && (bit_cnt != 5'd16);
        end else begin
          if (sclk_rise && bit_cnt != 5'd16) begin
            rx_nx  = {rx_shift[12:0], mosi_s2};
            cnt_nx = bit_cnt + 5'd1;
          end
          // The mode-3 leading fall precedes any sample, so the MSB must hold.
          if (sclk_fall && bit_cnt != 5'd0 && bit_cnt != 5'd16)
            tx_nx = {tx_shift[14:0], 1'b0};
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      ch_sel    <= INIT_CH;
      xfer_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      tx_shift  <= tx_nx;
      rx_shift  <= rx_nx;
      bit_cnt   <= cnt_nx;
      ch_sel    <= ch_nx;
      xfer_done <= done_nx;
      frame_err <= err_nx;
    end
  end

  assign MISO = (state == SHIFT) ? tx_shift[15] : 1'b0;

endmodule
